// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg: shared types and constants for the RV32M sequential unit.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package muldiv_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_NEG_A  = 3'd1,
      S_NEG_B  = 3'd2,
      S_ITER   = 3'd3,
      S_FIX_LO = 3'd4,
      S_FIX_HI = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [1:0] ALU_AND = 2'b00;
   localparam logic [1:0] ALU_OR  = 2'b01;
   localparam logic [1:0] ALU_ADD = 2'b10;
   localparam logic [1:0] ALU_SLT = 2'b11;

   function automatic logic a_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rv_muldiv_seq.sv
// ---------------------------------------------------------------------------
// rv_muldiv_seq: 36-cycle iterative RV32M multiply/divide using a shared ALU.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rv_muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic            alu_a_invert,
   output logic            alu_b_invert,
   output logic            alu_carry_in,
   output logic [1:0]      alu_op,
   input  logic [XLEN-1:0] alu_y,
   input  logic            alu_carry_out,
   input  logic            alu_zero
);

   state_t          state_q, state_d;
   logic [2:0]      f3_q, f3_d;
   logic [XLEN-1:0] lo_q, lo_d;   // |a|, then product low word or quotient
   logic [XLEN-1:0] hi_q, hi_d;   // product high word or remainder
   logic [XLEN-1:0] b_q, b_d;
   logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic            dbz_q, dbz_d, c_lo_q, c_lo_d;
   logic [4:0]      cnt_q, cnt_d;

   logic            is_div, mul_neg, lo_neg, hi_neg;
   logic [XLEN-1:0] r_sh, q_sh;

   assign is_div  = f3_q[2];
   assign mul_neg = sign_a_q ^ sign_b_q;
   assign lo_neg  = is_div ? (mul_neg & ~dbz_q) : mul_neg;
   assign hi_neg  = is_div ? sign_a_q : mul_neg;
   assign r_sh    = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
   assign q_sh    = {lo_q[XLEN-2:0], 1'b0};

   // ALU drive depends only on registered state, never on alu_y.
   always_comb begin
      alu_a        = '0;
      alu_b        = '0;
      alu_a_invert = 1'b0;
      alu_b_invert = 1'b0;
      alu_carry_in = 1'b0;
      alu_op       = ALU_AND;
      case (state_q)
         S_NEG_A, S_NEG_B, S_FIX_LO, S_FIX_HI: begin
            alu_op       = ALU_ADD;
            alu_b_invert = 1'b1;
            alu_carry_in = 1'b1;
            case (state_q)
               S_NEG_A:  alu_b = lo_q;
               S_NEG_B:  alu_b = b_q;
               S_FIX_LO: alu_b = lo_q;
               default: begin
                  alu_b        = hi_q;
                  alu_carry_in = is_div ? 1'b1 : c_lo_q;
               end
            endcase
         end
         S_ITER: begin
            alu_op = ALU_ADD;
            alu_b  = b_q;
            if (is_div) begin
               alu_a        = r_sh;
               alu_b_invert = 1'b1;
               alu_carry_in = 1'b1;
            end else begin
               alu_a = hi_q;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      f3_d       = f3_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      b_d        = b_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      dbz_d      = dbz_q;
      c_lo_d     = c_lo_q;
      cnt_d      = cnt_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_result = '0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               f3_d     = in_funct3;
               lo_d     = in_a;
               b_d      = in_b;
               hi_d     = '0;
               cnt_d    = '0;
               sign_a_d = a_is_signed(in_funct3) & in_a[XLEN-1];
               sign_b_d = b_is_signed(in_funct3) & in_b[XLEN-1];
               state_d  = S_NEG_A;
            end
         end
         S_NEG_A: begin
            if (sign_a_q) lo_d = alu_y;
            state_d = S_NEG_B;
         end
         S_NEG_B: begin
            if (sign_b_q) b_d = alu_y;
            dbz_d   = alu_zero;
            state_d = S_ITER;
         end
         S_ITER: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = S_FIX_LO;
            if (is_div) begin
               // Carry out of R_shifted - |b| means no borrow; ov covers a 33-bit R.
               if (hi_q[XLEN-1] | alu_carry_out) begin
                  hi_d = alu_y;
                  lo_d = q_sh | {{(XLEN-1){1'b0}}, 1'b1};
               end else begin
                  hi_d = r_sh;
                  lo_d = q_sh;
               end
            end else if (lo_q[0]) begin
               hi_d = {alu_carry_out, alu_y[XLEN-1:1]};
               lo_d = {alu_y[0], lo_q[XLEN-1:1]};
            end else begin
               hi_d = {1'b0, hi_q[XLEN-1:1]};
               lo_d = {hi_q[0], lo_q[XLEN-1:1]};
            end
         end
         S_FIX_LO: begin
            c_lo_d = alu_carry_out;
            if (lo_neg) lo_d = alu_y;
            state_d = S_FIX_HI;
         end
         S_FIX_HI: begin
            if (hi_neg) hi_d = alu_y;
            state_d = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            case (f3_q)
               F3_MUL, F3_DIV, F3_DIVU: out_result = lo_q;
               default:                 out_result = hi_q;
            endcase
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         f3_q     <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         b_q      <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         dbz_q    <= 1'b0;
         c_lo_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         f3_q     <= f3_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         b_q      <= b_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         dbz_q    <= dbz_d;
         c_lo_q   <= c_lo_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rv_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_rv_muldiv_seq: vector table + scoreboard bench with a behavioural ALU.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rv_muldiv_seq;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  in_funct3;
   logic [31:0] in_a, in_b, out_result;
   logic [31:0] alu_a, alu_b, alu_y;
   logic        alu_a_invert, alu_b_invert, alu_carry_in, alu_carry_out, alu_zero;
   logic [1:0]  alu_op;

   int errors = 0;
   int checks = 0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   rv_muldiv_seq #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_a_invert(alu_a_invert),
      .alu_b_invert(alu_b_invert), .alu_carry_in(alu_carry_in), .alu_op(alu_op),
      .alu_y(alu_y), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero)
   );

   // Behavioural shared ALU.
   logic [31:0] ea, eb;
   logic [32:0] sum;
   always_comb begin
      ea  = alu_a_invert ? ~alu_a : alu_a;
      eb  = alu_b_invert ? ~alu_b : alu_b;
      sum = {1'b0, ea} + {1'b0, eb} + {32'd0, alu_carry_in};
      alu_carry_out = 1'b0;
      case (alu_op)
         2'b00: alu_y = ea & eb;
         2'b01: alu_y = ea | eb;
         2'b10: begin alu_y = sum[31:0]; alu_carry_out = sum[32]; end
         default: alu_y = {31'd0, sum[31] ^ ((ea[31] == eb[31]) && (sum[31] != ea[31]))};
      endcase
      alu_zero = (alu_y == 32'd0);
   end

   function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, sub, p;
      logic [63:0] up;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      sub = {32'd0, b};
      case (f3)
         3'b000: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * sub; return p[63:32]; end
         3'b011: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name, input int hold);
      int lat;
      logic [31:0] want;
      check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_funct3 = f3; in_a = a; in_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb_q.push_back(exp);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, " latency"}, lat, 32'd36);
      if (out_valid === 1'b1) begin
         want = (sb_q.size() > 0) ? sb_q.pop_front() : ~out_result;
         check(name, out_result, want);
         for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_funct3 = ~f3; in_a = ~a; in_b = 32'd1;
            @(posedge clk); #1;
            check({name, " held result"}, out_result, want);
            check({name, " held in_ready"}, {31'd0, in_ready}, 32'd0);
            check({name, " held out_valid"}, {31'd0, out_valid}, 32'd1);
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         check({name, " drained"}, {31'd0, out_valid}, 32'd0);
      end else begin
         sb_q.delete();
      end
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, "mul 7*-3"};
      vecs[1]  = '{F3_MULH,   32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, "mulh 7*-3"};
      vecs[2]  = '{F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu max"};
      vecs[3]  = '{F3_MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, "mulhsu -1*2"};
      vecs[4]  = '{F3_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, "div -7/2"};
      vecs[5]  = '{F3_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, "rem -7%2"};
      vecs[6]  = '{F3_DIVU,   32'd100,        32'd7,        32'd14,       "divu 100/7"};
      vecs[7]  = '{F3_REMU,   32'd100,        32'd7,        32'd2,        "remu 100/7"};
      vecs[8]  = '{F3_DIV,    32'h12345678,   32'd0,        32'hFFFFFFFF, "div by 0"};
      vecs[9]  = '{F3_REM,    32'h12345678,   32'd0,        32'h12345678, "rem by 0"};
      vecs[10] = '{F3_REM,    32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, "rem neg by 0"};
      vecs[11] = '{F3_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, "div overflow"};
      vecs[12] = '{F3_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        "rem overflow"};
      vecs[13] = '{F3_MULH,   32'h80000000,   32'h80000000, 32'h40000000, "mulh min*min"};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_funct3 = 3'd0; in_a = 32'd0; in_b = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset out_result", out_result, 32'd0);
      check("reset alu ctl", {27'd0, alu_a_invert, alu_b_invert, alu_carry_in, alu_op}, 32'd0);
      check("reset alu ops", alu_a | alu_b, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++)
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 0);

      for (int i = 0; i < 12; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (i % 4 == 3) ? 32'd0 : ((i % 4 == 2) ? 32'($urandom_range(1, 300)) : $urandom);
         run_op(f3, a, b, ref_op(f3, a, b), "random", 0);
      end

      // First cycle after accept must drive 0 - a through the ALU.
      in_valid = 1'b1; in_funct3 = F3_DIV; in_a = 32'h55; in_b = 32'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("neg_a alu ctl", {27'd0, alu_a_invert, alu_b_invert, alu_carry_in, alu_op},
            {27'd0, 1'b0, 1'b1, 1'b1, ALU_ADD});
      check("neg_a alu_b", alu_b, 32'h55);
      repeat (40) begin
         if (out_valid !== 1'b1) begin @(posedge clk); #1; end
      end
      check("neg_a op result", out_result, 32'd28);
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;

      run_op(F3_DIVU, 32'd1000, 32'd9, 32'd111, "backpressure", 5);
      run_op(F3_REMU, 32'd1000, 32'd9, 32'd1, "after backpressure", 0);

      in_valid = 1'b1; in_funct3 = F3_MULHU; in_a = 32'hDEADBEEF; in_b = 32'h12345;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst out_valid", {31'd0, out_valid}, 32'd0);
      check("async rst in_ready", {31'd0, in_ready}, 32'd1);
      check("async rst alu_op", {30'd0, alu_op}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(F3_MUL, 32'd3, 32'd5, 32'd15, "mul after reset", 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rv_muldiv_seq.md
# rv_muldiv_seq

Iterative RV32M multiply/divide unit that sits beside the integer ALU in the execute stage. It implements MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a fixed 36-cycle sequence. It acts as the initiator toward the shared 32-bit ALU: each cycle it drives operands plus the ALU control fields (A invert, B invert, carry-in, 2-bit op) and consumes the ALU's Y, CarryOut and Zero. Requests and results use valid/ready handshakes.

## Interface
- XLEN, 32, operand width; only 32 is supported.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit idle, can accept a request.
- in_funct3  in  3  RV32M funct3 (000 MUL … 111 REMU).
- in_a, in_b  in  32 each  rs1 and rs2 values.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  32  result.
- alu_a, alu_b  out  32 each  ALU operands.
- alu_a_invert, alu_b_invert, alu_carry_in  out  1 each  ALU controls.
- alu_op  out  2  ALU op: 00 AND, 01 OR, 10 ADD, 11 SLT.
- alu_y  in  32  ALU result.
- alu_carry_out, alu_zero  in  1 each  ALU flags.

## Operation
- **States:**
  - IDLE → NEG_A → NEG_B → ITER (32 cycles, 5-bit count) → FIX_LO → FIX_HI → DONE → IDLE.
- **IDLE:**
  - in_ready=1.
  - On in_valid: latch funct3 and operands, set signed flags, go to NEG_A.
  - A is signed for MULH, MULHSU, DIV, REM; B is signed for MULH, DIV, REM.
- **NEG_A / NEG_B:**
  - ALU computes 0−x: alu_a=0, alu_b=x, b_invert=1, carry_in=1, op=ADD.
  - The magnitude register takes alu_y only if x is signed and x[31]=1.
  - NEG_B also latches div_by_zero = alu_zero.
- **ITER, multiply (unsigned shift-add):**
  - Product register {hi,lo} starts as {0, |a|}; multiplicand is |b|.
  - If lo[0]=1, the ALU computes hi+|b| (op=ADD, carry_in=0) and {alu_carry_out, alu_y, lo} is shifted right 1.
  - Otherwise {0, hi, lo} is shifted right 1.
- **ITER, divide (restoring):**
  - Registers: R (32b, starts 0), Q = |a|.
  - Shift {R,Q} left 1; the bit shifted out of R is `ov`.
  - The ALU computes R_shifted − |b| (b_invert=1, carry_in=1, op=ADD).
  - If ov | alu_carry_out: R=alu_y and Q[0]=1. Otherwise R keeps R_shifted and Q[0]=0.
- **Sign fix:**
  - Multiply negate flag = sign(a)^sign(b), using signed flags only.
  - Quotient negate flag = sign(a)^sign(b) & ~div_by_zero.
  - Remainder negate flag = sign(a).
  - FIX_LO: low word (lo or Q) ← 0−low when its flag is set; the carry_out is stored as c_lo.
  - FIX_HI, multiply: hi ← ~hi + c_lo (a=0, b_invert=1, carry_in=c_lo), applied only if negate.
  - FIX_HI, divide: R ← 0−R if the remainder flag is set (carry_in=1).
- **Result select:**
  - MUL → lo.
  - MULH/MULHSU/MULHU → hi.
  - DIV/DIVU → Q.
  - REM/REMU → R.
- **Divide by zero:** the iteration naturally yields Q=0xFFFFFFFF and R=dividend; the sign rules above preserve the RISC-V results.
- **Overflow (−2³¹ / −1):** yields 0x80000000 with remainder 0; no special case is needed.
- **ALU drive when unused** (IDLE, DONE): all ALU outputs are 0 and op=AND.

## Timing
- **Reset:** async to IDLE. in_ready=1; out_valid=0; out_result=0; all ALU control outputs 0.
- **Acceptance:** on the rising edge with in_valid & in_ready.
- **Fixed latency:** out_valid rises on the 36th rising edge after the accepting edge (NEG_A, NEG_B, 32×ITER, FIX_LO, FIX_HI). It does not depend on the data or funct3.
- **Backpressure:**
  - out_valid and out_result are held stable until out_ready=1 on an edge; the unit then returns to IDLE.
  - in_ready=0 in every state other than IDLE; in_valid is ignored while busy.
- **Reset mid-operation:** aborts immediately; no result is emitted. The next request after release computes correctly.
- **Output registering:** ALU control outputs are combinational from state and registers. alu_y and the flags are sampled at the end of the same cycle.

## Structure
- **Package muldiv_pkg:**
  - state enum.
  - funct3 constants (F3_MUL … F3_REMU).
  - ALU op constants: ALU_AND=2'b00, ALU_OR=2'b01, ALU_ADD=2'b10, ALU_SLT=2'b11.
- Single module; FSM and datapath registers together. No sub-module.
- The ALU is external, instantiated by the execute stage and multiplexed onto this unit while it is busy.

## Test plan
- MUL a=7, b=0xFFFFFFFD → 0xFFFFFFEB; MULH on the same operands → 0xFFFFFFFF. out_valid exactly 36 edges after accept.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7%2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 0x12345678/0 → 0xFFFFFFFF; REM → 0x12345678; REM 0xFFFFFFF9/0 → 0xFFFFFFF9; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- Hold out_ready=0 for 5 cycles after out_valid: out_result stable, in_ready=0, in_valid pulses ignored. The following request completes normally.
- Pull rst_n low at ITER count 10 → out_valid=0, in_ready=1 asynchronously. After release, MUL 3×5 → 15.
